// File: rtl/hamming_secded_dec.sv
// hamming_secded_dec: two-stage pipelined SECDED Hamming decoder with valid/ready flow control.
// Error-event counters are built only when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_dec #(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16,
  localparam int R = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int N = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [R-1:0]      syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              adv;
  logic [R-1:0]      syn_c;
  logic              par_c;
  logic              v1;
  logic [N-1:0]      code1;
  logic [R-1:0]      syn1;
  logic              par1;
  logic              in_range;
  logic [N-1:0]      fixed;
  logic [DATA_W-1:0] data_c;
  logic              corr_c;
  logic              uncorr_c;
  logic              unused_par_bit;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Syndrome is the XOR of the indices of every set Hamming position.
  always_comb begin
    syn_c = '0;
    for (int i = 1; i < N; i++) begin
      if (code_in[i]) syn_c = syn_c ^ R'(i);
    end
  end

  assign par_c = ^code_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      code1 <= '0;
      syn1  <= '0;
      par1  <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        code1 <= code_in;
        syn1  <= syn_c;
        par1  <= par_c;
      end
    end
  end

  // A syndrome beyond the last codeword position cannot name a real bit.
  assign in_range = (int'(syn1) <= N - 1);
  assign corr_c   = par1 & in_range;
  assign uncorr_c = (syn1 != '0) & (~par1 | ~in_range);

  always_comb begin
    int k;
    fixed  = code1;
    data_c = '0;
    k      = 0;
    for (int i = 1; i < N; i++) begin
      if (corr_c && (syn1 == R'(i))) fixed[i] = ~fixed[i];
    end
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_c[k] = fixed[i];
        k++;
      end
    end
  end

  assign unused_par_bit = fixed[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= '0;
    end else if (adv) begin
      out_valid <= v1;
      if (v1) begin
        data_out   <= data_c;
        err_corr   <= corr_c;
        err_uncorr <= uncorr_c;
        syndrome   <= syn1;
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;

  // Clear has priority over a coincident increment; counts saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (err_corr && (corr_cnt != {CNT_W{1'b1}}))
        corr_cnt <= corr_cnt + 1'b1;
      if (err_uncorr && (uncorr_cnt != {CNT_W{1'b1}}))
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed self-checking bench for hamming_secded_dec at DATA_W=4 (N=8); counter
// expectations follow whether HAMMING_ERR_CNT_EN is defined for the build.
module tb_hamming_secded_dec;

`ifdef HAMMING_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       err_corr;
  logic       err_uncorr;
  logic [2:0] syndrome;
  logic       cnt_clr;
  logic [3:0] corr_cnt;
  logic [3:0] uncorr_cnt;

  int checks = 0;
  int errors = 0;

  hamming_secded_dec #(.DATA_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .syndrome(syndrome),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] code, input logic rdy, input logic clr);
    in_valid  = v;
    code_in   = code;
    out_ready = rdy;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [3:0] d, input logic c,
                           input logic u, input logic [2:0] s);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_data"}, data_out, d);
    checkOutput({tag, "_corr"}, err_corr, c);
    checkOutput({tag, "_uncorr"}, err_uncorr, u);
    checkOutput({tag, "_syn"}, syndrome, s);
  endtask

  task automatic sendWord(input string tag, input logic [7:0] code);
    applyStimulus(1'b1, code, 1'b1, 1'b0);
    checkOutput({tag, "_lat1"}, out_valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_flags", {err_corr, err_uncorr}, 0);
    checkOutput("rst_syn", syndrome, 0);
    checkOutput("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Single words with out_ready held high
    sendWord("clean", 8'hAA);  checkWord("clean", 4'hB, 0, 0, 3'd0);
    sendWord("pos5", 8'h8A);   checkWord("pos5", 4'hB, 1, 0, 3'd5);
    sendWord("par0", 8'hAB);   checkWord("par0", 4'hB, 1, 0, 3'd0);
    sendWord("dbl12", 8'hAC);  checkWord("dbl12", 4'hB, 0, 1, 3'd3);
    sendWord("pos6", 8'hEA);   checkWord("pos6", 4'hB, 1, 0, 3'd6);
    sendWord("pos4", 8'hBA);   checkWord("pos4", 4'hB, 1, 0, 3'd4);
    sendWord("zero", 8'h00);   checkWord("zero", 4'h0, 0, 0, 3'd0);
    sendWord("d5", 8'h5A);     checkWord("d5", 4'h5, 0, 0, 3'd0);
    sendWord("d5pos7", 8'hDA); checkWord("d5pos7", 4'h5, 1, 0, 3'd7);
    sendWord("d5dbl", 8'hDB);  checkWord("d5dbl", 4'hD, 0, 1, 3'd7);

    // Back-to-back stream with a three-cycle output stall
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h8A, 1'b1, 1'b0);
    in_valid = 1'b1; code_in = 8'hAC; out_ready = 1'b0;
    #1;
    checkOutput("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hAC, 1'b0, 1'b0);
      checkOutput("stall_hold_in_ready", in_ready, 0);
      checkWord("stall_hold", 4'hB, 0, 0, 3'd0);
    end
    applyStimulus(1'b1, 8'hAC, 1'b1, 1'b0);
    checkWord("stream_w2", 4'hB, 1, 0, 3'd5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkWord("stream_w3", 4'hB, 0, 1, 3'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_drained", out_valid, 0);
    checkOutput("tally_corr", corr_cnt, CNT_EN ? 32'd6 : 32'd0);
    checkOutput("tally_uncorr", uncorr_cnt, CNT_EN ? 32'd3 : 32'd0);

    // Clear, saturation, and clear beating a coincident increment
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("clr_cnts", {corr_cnt, uncorr_cnt}, 0);
    repeat (17) applyStimulus(1'b1, 8'h8A, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("sat_corr", corr_cnt, CNT_EN ? 32'd15 : 32'd0);
    checkOutput("sat_uncorr", uncorr_cnt, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    sendWord("one_corr", 8'h8A);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("one_corr_cnt", corr_cnt, CNT_EN ? 32'd1 : 32'd0);
    sendWord("coinc", 8'h8A);
    checkOutput("coinc_valid", out_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("coinc_clr_wins", corr_cnt, 0);
    cnt_clr = 1'b0;

    // Reset with two words in flight
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h8A, 1'b1, 1'b0);
    checkOutput("flight_valid", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_data", data_out, 0);
    checkOutput("async_rst_flags", {err_corr, err_uncorr, syndrome}, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("no_stale_word", out_valid, 0);
    end
    checkOutput("rst_cnts_after", {corr_cnt, uncorr_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
